// File: rtl/wb_buffer.sv
// wb_buffer: in-order write-back queue between the ALU / memory result paths
// and the register file's single write port, with pending-write lookup for
// decode-stage forwarding.

`ifndef REG_ADDR
`define REG_ADDR 5
`endif
`ifndef REG_SIZE
`define REG_SIZE 32
`endif

module wb_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = `REG_ADDR,
  parameter int DW    = `REG_SIZE
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     a_valid,
  input  logic [AW-1:0]            a_reg,
  input  logic [DW-1:0]            a_data,
  input  logic                     b_valid,
  input  logic [AW-1:0]            b_reg,
  input  logic [DW-1:0]            b_data,
  output logic                     in_ready,
  output logic                     regwrite,
  output logic [AW-1:0]            wreg,
  output logic [DW-1:0]            wdata,
  input  logic [AW-1:0]            rreg1,
  input  logic [AW-1:0]            rreg2,
  output logic                     hit1,
  output logic                     hit2,
  output logic [DW-1:0]            fwd1,
  output logic [DW-1:0]            fwd2,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  // Two free slots are needed because both sources may push in one cycle.
  localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - 2);

  logic [AW-1:0]    ent_reg  [DEPTH];
  logic [DW-1:0]    ent_data [DEPTH];
  logic [DEPTH-1:0] ent_valid;

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW-1:0] b_slot;
  logic [PW-1:0] scan_idx;
  logic [CW-1:0] count_q;
  logic [1:0]    num_push;

  logic a_req;
  logic b_req;
  logic push_a;
  logic push_b;
  logic pop;

  assign count    = count_q;
  assign empty    = (count_q == '0);
  assign in_ready = (count_q <= READY_MAX);

  // Register 0 is never stored; a request only counts if it targets a real register.
  assign a_req  = a_valid && (a_reg != '0);
  assign b_req  = b_valid && (b_reg != '0);
  assign push_a = a_req && in_ready;
  assign push_b = b_req && in_ready;
  assign pop    = !empty;

  // A is always older than B, so B lands one slot past A when both push.
  assign b_slot   = push_a ? (tail + PW'(1)) : tail;
  assign num_push = {1'b0, push_a} + {1'b0, push_b};

  // Head entry drives the register file write port directly.
  assign regwrite = !empty;
  assign wreg     = empty ? '0 : ent_reg[head];
  assign wdata    = empty ? '0 : ent_data[head];

  // Pointers, occupancy and per-entry valid bits; reset discards everything pending.
  always_ff @(posedge clk) begin
    if (reset) begin
      head      <= '0;
      tail      <= '0;
      count_q   <= '0;
      ent_valid <= '0;
    end else begin
      head    <= head + PW'(pop);
      tail    <= tail + PW'(num_push);
      count_q <= count_q + CW'(num_push) - CW'(pop);
      if (pop)    ent_valid[head]   <= 1'b0;
      if (push_a) ent_valid[tail]   <= 1'b1;
      if (push_b) ent_valid[b_slot] <= 1'b1;
    end
  end

  // Entry payload storage; contents of invalid slots are don't-care so no reset.
  always_ff @(posedge clk) begin
    if (push_a) begin
      ent_reg[tail]  <= a_reg;
      ent_data[tail] <= a_data;
    end
    if (push_b) begin
      ent_reg[b_slot]  <= b_reg;
      ent_data[b_slot] <= b_data;
    end
  end

  // Sticky error: a real push arrived while the queue could not take it.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (!in_ready && (a_req || b_req)) begin
      overflow <= 1'b1;
    end
  end

  // Forwarding lookup: walk oldest to youngest so the last match is the youngest.
  always_comb begin
    hit1     = 1'b0;
    fwd1     = '0;
    hit2     = 1'b0;
    fwd2     = '0;
    scan_idx = head;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = head + PW'(i);
      if (ent_valid[scan_idx]) begin
        if ((rreg1 != '0) && (ent_reg[scan_idx] == rreg1)) begin
          hit1 = 1'b1;
          fwd1 = ent_data[scan_idx];
        end
        if ((rreg2 != '0) && (ent_reg[scan_idx] == rreg2)) begin
          hit2 = 1'b1;
          fwd2 = ent_data[scan_idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_buffer.sv
// tb_wb_buffer: directed scenarios plus randomized traffic for wb_buffer,
// compared against a queue-based reference model of the write-back buffer.

module tb_wb_buffer;

  localparam int DEPTH = 4;
  localparam int AW    = 5;
  localparam int DW    = 16;

  logic          clk;
  logic          reset;
  logic          a_valid;
  logic [AW-1:0] a_reg;
  logic [DW-1:0] a_data;
  logic          b_valid;
  logic [AW-1:0] b_reg;
  logic [DW-1:0] b_data;
  logic          in_ready;
  logic          regwrite;
  logic [AW-1:0] wreg;
  logic [DW-1:0] wdata;
  logic [AW-1:0] rreg1;
  logic [AW-1:0] rreg2;
  logic          hit1;
  logic          hit2;
  logic [DW-1:0] fwd1;
  logic [DW-1:0] fwd2;
  logic [2:0]    count;
  logic          empty;
  logic          overflow;

  int checks = 0;
  int errors = 0;

  wb_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_reg(a_reg), .a_data(a_data),
    .b_valid(b_valid), .b_reg(b_reg), .b_data(b_data),
    .in_ready(in_ready), .regwrite(regwrite), .wreg(wreg), .wdata(wdata),
    .rreg1(rreg1), .rreg2(rreg2), .hit1(hit1), .hit2(hit2),
    .fwd1(fwd1), .fwd2(fwd2), .count(count), .empty(empty), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a plain FIFO of (register, data) pairs plus a sticky flag.
  typedef struct {
    logic [AW-1:0] r;
    logic [DW-1:0] d;
  } ent_t;

  ent_t q[$];
  bit   m_ovf = 1'b0;

  function automatic bit model_room();
    return (DEPTH - q.size()) >= 2;
  endfunction

  // Advance the model by one clock edge using the inputs seen at that edge.
  task automatic model_update();
    bit   room;
    ent_t e;
    if (reset) begin
      q.delete();
      m_ovf = 1'b0;
    end else begin
      room = model_room();
      if (q.size() > 0) void'(q.pop_front());
      if (a_valid && a_reg != '0) begin
        if (room) begin e.r = a_reg; e.d = a_data; q.push_back(e); end
        else m_ovf = 1'b1;
      end
      if (b_valid && b_reg != '0) begin
        if (room) begin e.r = b_reg; e.d = b_data; q.push_back(e); end
        else m_ovf = 1'b1;
      end
    end
  endtask

  // Youngest pending entry for a register index; index 0 never matches.
  function automatic logic [DW:0] model_lookup(input logic [AW-1:0] rr);
    if (rr != '0) begin
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].r == rr) return {1'b1, q[i].d};
      end
    end
    return '0;
  endfunction

  task automatic clock_edge();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic applyStimulus(input bit av, input logic [AW-1:0] ar, input logic [DW-1:0] ad,
                               input bit bv, input logic [AW-1:0] br, input logic [DW-1:0] bd);
    a_valid = av; a_reg = ar; a_data = ad;
    b_valid = bv; b_reg = br; b_data = bd;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0);
    rreg1 = 5'd3;
    rreg2 = 5'd3;
    clock_edge();
    clock_edge();
    reset = 1'b0;
    clock_edge();
    checks++; if (regwrite !== 1'b0) begin errors++; $display("[TB] FAIL reset_regwrite got %0b want 0", regwrite); end
    checks++; if (empty !== 1'b1) begin errors++; $display("[TB] FAIL reset_empty got %0b want 1", empty); end
    checks++; if (count !== 3'd0) begin errors++; $display("[TB] FAIL reset_count got %0d want 0", count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready got %0b want 1", in_ready); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow got %0b want 0", overflow); end
    checks++; if ({wreg, wdata} !== '0) begin errors++; $display("[TB] FAIL reset_wport got %0h/%0h want 0/0", wreg, wdata); end
    checks++; if ({hit1, fwd1, hit2, fwd2} !== '0) begin errors++; $display("[TB] FAIL reset_lookup got hit1=%0b fwd1=%0h want 0/0", hit1, fwd1); end
  endtask

  task automatic test_single_write();
    applyStimulus(1, 5'd3, 16'h0011, 0, 0, 0);
    clock_edge();
    applyStimulus(0, 0, 0, 0, 0, 0);
    checks++; if ({regwrite, wreg, wdata} !== {1'b1, 5'd3, 16'h0011}) begin
      errors++; $display("[TB] FAIL single_head got rw=%0b wreg=%0d wdata=%0h want 1/3/11", regwrite, wreg, wdata); end
    checks++; if (count !== 3'd1) begin errors++; $display("[TB] FAIL single_count1 got %0d want 1", count); end
    clock_edge();
    checks++; if (regwrite !== 1'b0) begin errors++; $display("[TB] FAIL single_drained got %0b want 0", regwrite); end
    checks++; if (count !== 3'd0) begin errors++; $display("[TB] FAIL single_count0 got %0d want 0", count); end
  endtask

  task automatic test_ordering_forward();
    rreg1 = 5'd5;
    applyStimulus(1, 5'd5, 16'h00AA, 1, 5'd5, 16'h00BB);
    clock_edge();
    applyStimulus(0, 0, 0, 0, 0, 0);
    checks++; if ({hit1, fwd1} !== {1'b1, 16'h00BB}) begin errors++; $display("[TB] FAIL order_fwd_both got %0b/%0h want 1/bb", hit1, fwd1); end
    checks++; if (wdata !== 16'h00AA) begin errors++; $display("[TB] FAIL order_first got %0h want aa", wdata); end
    checks++; if (count !== 3'd2) begin errors++; $display("[TB] FAIL order_count got %0d want 2", count); end
    clock_edge();
    checks++; if ({regwrite, wreg, wdata} !== {1'b1, 5'd5, 16'h00BB}) begin errors++; $display("[TB] FAIL order_second got %0b/%0d/%0h want 1/5/bb", regwrite, wreg, wdata); end
    checks++; if ({hit1, fwd1} !== {1'b1, 16'h00BB}) begin errors++; $display("[TB] FAIL order_fwd_head got %0b/%0h want 1/bb", hit1, fwd1); end
    clock_edge();
    checks++; if ({regwrite, hit1, fwd1} !== '0) begin errors++; $display("[TB] FAIL order_done got rw=%0b hit1=%0b fwd1=%0h want 0/0/0", regwrite, hit1, fwd1); end
  endtask

  task automatic test_reg0();
    rreg2 = 5'd0;
    applyStimulus(1, 5'd0, 16'h00FF, 0, 0, 0);
    clock_edge();
    applyStimulus(0, 0, 0, 0, 0, 0);
    checks++; if (count !== 3'd0) begin errors++; $display("[TB] FAIL reg0_count got %0d want 0", count); end
    checks++; if (regwrite !== 1'b0) begin errors++; $display("[TB] FAIL reg0_regwrite got %0b want 0", regwrite); end
    checks++; if ({hit2, fwd2} !== '0) begin errors++; $display("[TB] FAIL reg0_lookup got %0b/%0h want 0/0", hit2, fwd2); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL reg0_overflow got %0b want 0", overflow); end
  endtask

  task automatic test_fill_overflow();
    logic [2:0] exp_count [3] = '{3'd2, 3'd3, 3'd2};
    bit         exp_rdy   [3] = '{1'b1, 1'b0, 1'b1};
    bit         exp_ovf   [3] = '{1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, 5'(10 + 2 * k), 16'(16'h0100 + k), 1, 5'(11 + 2 * k), 16'(16'h0200 + k));
      clock_edge();
      checks++; if (count !== exp_count[k]) begin errors++; $display("[TB] FAIL fill_count[%0d] got %0d want %0d", k, count, exp_count[k]); end
      checks++; if (in_ready !== exp_rdy[k]) begin errors++; $display("[TB] FAIL fill_in_ready[%0d] got %0b want %0b", k, in_ready, exp_rdy[k]); end
      checks++; if (overflow !== exp_ovf[k]) begin errors++; $display("[TB] FAIL fill_overflow[%0d] got %0b want %0b", k, overflow, exp_ovf[k]); end
    end
    applyStimulus(0, 0, 0, 0, 0, 0);
    checks++; if ({wreg, wdata} !== {5'd12, 16'h0101}) begin errors++; $display("[TB] FAIL fill_drain0 got %0d/%0h want 12/101", wreg, wdata); end
    clock_edge();
    checks++; if ({wreg, wdata} !== {5'd13, 16'h0201}) begin errors++; $display("[TB] FAIL fill_drain1 got %0d/%0h want 13/201", wreg, wdata); end
    clock_edge();
    checks++; if ({empty, overflow} !== 2'b11) begin errors++; $display("[TB] FAIL fill_sticky got empty=%0b ovf=%0b want 1/1", empty, overflow); end
  endtask

  task automatic test_reset_mid();
    applyStimulus(1, 5'd20, 16'h1000, 1, 5'd21, 16'h1001);
    clock_edge();
    applyStimulus(1, 5'd22, 16'h1002, 1, 5'd23, 16'h1003);
    clock_edge();
    applyStimulus(0, 0, 0, 0, 0, 0);
    checks++; if (count !== 3'd3) begin errors++; $display("[TB] FAIL mid_pending got %0d want 3", count); end
    reset = 1'b1;
    clock_edge();
    reset = 1'b0;
    checks++; if ({empty, regwrite, overflow} !== 3'b100) begin errors++; $display("[TB] FAIL mid_reset got empty=%0b rw=%0b ovf=%0b want 1/0/0", empty, regwrite, overflow); end
    for (int k = 0; k < 6; k++) begin
      clock_edge();
      checks++; if (regwrite || (wreg inside {5'd21, 5'd22, 5'd23})) begin
        errors++; $display("[TB] FAIL mid_leak[%0d] got rw=%0b wreg=%0d want 0/none", k, regwrite, wreg); end
    end
  endtask

  task automatic test_random();
    logic [DW:0] l1;
    logic [DW:0] l2;
    bool_t_dummy: begin end
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 3) != 0 && !model_room()) begin
        applyStimulus(0, 5'($urandom_range(0, 7)), 16'($urandom), 0, 5'($urandom_range(0, 7)), 16'($urandom));
      end else begin
        applyStimulus($urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), 16'($urandom),
                      $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), 16'($urandom));
      end
      rreg1 = 5'($urandom_range(0, 7));
      rreg2 = 5'($urandom_range(0, 7));
      #1;
      l1 = model_lookup(rreg1);
      l2 = model_lookup(rreg2);
      checks++;
      if (q.size() == 0) begin
        if ({regwrite, wreg, wdata} !== '0) begin errors++; $display("[TB] FAIL rand_head[%0d] got %0b/%0d/%0h want 0/0/0", n, regwrite, wreg, wdata); end
      end else if ({regwrite, wreg, wdata} !== {1'b1, q[0].r, q[0].d}) begin
        errors++; $display("[TB] FAIL rand_head[%0d] got %0b/%0d/%0h want 1/%0d/%0h", n, regwrite, wreg, wdata, q[0].r, q[0].d);
      end
      checks++;
      if ({count, empty, in_ready, overflow} !== {3'(q.size()), q.size() == 0, model_room(), m_ovf}) begin
        errors++; $display("[TB] FAIL rand_status[%0d] got cnt=%0d e=%0b rdy=%0b ovf=%0b want %0d/%0b/%0b/%0b",
                           n, count, empty, in_ready, overflow, q.size(), q.size() == 0, model_room(), m_ovf);
      end
      checks++;
      if ({hit1, fwd1, hit2, fwd2} !== {l1, l2}) begin
        errors++; $display("[TB] FAIL rand_lookup[%0d] got %0b/%0h %0b/%0h want %0b/%0h %0b/%0h",
                           n, hit1, fwd1, hit2, fwd2, l1[DW], l1[DW-1:0], l2[DW], l2[DW-1:0]);
      end
      clock_edge();
    end
    reset = 1'b0;
  endtask

  task automatic checkOutput();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0);
    rreg1 = '0;
    rreg2 = '0;
    test_reset();
    test_single_write();
    test_ordering_forward();
    test_reg0();
    test_fill_overflow();
    test_reset_mid();
    test_random();
    checkOutput();
    $finish;
  end

endmodule
